// File: rtl/cnn_pe_sequencer.sv
// cnn_pe_sequencer: broadcast controller for the CNN_POOL_ReLU PE array.
// Runs each layer through weight load, convolution, pooling and finish phases.
// Optional build macro CNN_SEQ_PERF_CNT_EN adds the stall_cnt output, which
// counts CONV cycles where the sequencer was ready but no activation arrived.
`timescale 1ns/1ps
module cnn_pe_sequencer #(
  parameter int ICP_NUM  = 4,
  parameter int DATA_W   = 8,
  parameter int ADDR_B   = 5,
  parameter int DEPTH    = 18,
  parameter int POOL_CYC = 4,
  parameter int CNT_B    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_B-1:0]           cfg_depth,
  input  logic [CNT_B-1:0]            cfg_nact,
  input  logic                        w_valid,
  input  logic [DATA_W-1:0]           w_data,
  output logic                        w_ready,
  input  logic                        a_valid,
  input  logic [ICP_NUM*DATA_W-1:0]   a_data,
  output logic                        a_ready,
  output logic [2:0]                  pe_state,
  output logic signed [DATA_W-1:0]    a_out [ICP_NUM],
  output logic signed [DATA_W-1:0]    wrb_data,
  output logic [ICP_NUM-1:0]          wrb_mask,
  output logic [ADDR_B-1:0]           wrb_addr,
  output logic [ADDR_B-1:0]           rdb_addr,
  output logic                        busy,
  output logic                        done
`ifdef CNN_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                 stall_cnt
`endif
);

  localparam int LANE_W = (ICP_NUM > 1) ? $clog2(ICP_NUM) : 1;
  localparam int POOL_W = $clog2(POOL_CYC + 1);

  // PE state codes seen by every PE lane
  localparam logic [2:0] PE_INVALID   = 3'd0;
  localparam logic [2:0] PE_WEIGHT_LD = 3'd1;
  localparam logic [2:0] PE_CONV      = 3'd2;
  localparam logic [2:0] PE_POOL      = 3'd3;
  localparam logic [2:0] PE_POOL_FIN  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_CONV,
    S_POOL,
    S_FIN
  } state_t;

  state_t              state;
  logic [ADDR_B-1:0]   depth_q;
  logic [CNT_B-1:0]    nact_q;
  logic [LANE_W-1:0]   lane;
  logic [ADDR_B-1:0]   wr_addr;
  logic [ADDR_B-1:0]   rd_cnt;
  logic [CNT_B-1:0]    beat_cnt;
  logic [POOL_W-1:0]   pool_cnt;

  // Zero or oversized depth requests fall back to the full buffer
  function automatic logic [ADDR_B-1:0] clamp_depth(input logic [ADDR_B-1:0] d);
    if (d == '0 || d > ADDR_B'(DEPTH)) return ADDR_B'(DEPTH);
    return d;
  endfunction

  // Layer sequencer; every output is registered one cycle after its handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pe_state <= PE_INVALID;
      for (int i = 0; i < ICP_NUM; i++) a_out[i] <= '0;
      wrb_data <= '0;
      wrb_mask <= '0;
      wrb_addr <= '0;
      rdb_addr <= '0;
      w_ready  <= 1'b0;
      a_ready  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      depth_q  <= '0;
      nact_q   <= '0;
      lane     <= '0;
      wr_addr  <= '0;
      rd_cnt   <= '0;
      beat_cnt <= '0;
      pool_cnt <= '0;
    end else begin
      wrb_mask <= '0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            depth_q  <= clamp_depth(cfg_depth);
            nact_q   <= cfg_nact;
            lane     <= '0;
            wr_addr  <= '0;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            pool_cnt <= '0;
            w_ready  <= 1'b1;
            busy     <= 1'b1;
            pe_state <= PE_WEIGHT_LD;
            state    <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (w_valid && w_ready) begin
            wrb_data <= $signed(w_data);
            wrb_mask <= ICP_NUM'(1) << lane;
            wrb_addr <= wr_addr;
            if (lane == LANE_W'(ICP_NUM - 1)) begin
              lane <= '0;
              if (wr_addr == depth_q - 1'b1) begin
                // last word: the final write still shows as WEIGHT_LD next cycle
                w_ready <= 1'b0;
                if (nact_q == '0) begin
                  state <= S_POOL;
                end else begin
                  a_ready <= 1'b1;
                  state   <= S_CONV;
                end
              end else begin
                wr_addr <= wr_addr + 1'b1;
              end
            end else begin
              lane <= lane + 1'b1;
            end
          end
        end
        S_CONV: begin
          if (a_valid && a_ready) begin
            for (int i = 0; i < ICP_NUM; i++)
              a_out[i] <= $signed(a_data[i*DATA_W +: DATA_W]);
            rdb_addr <= rd_cnt;
            pe_state <= PE_CONV;
            rd_cnt   <= (rd_cnt == depth_q - 1'b1) ? '0 : rd_cnt + 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == nact_q - 1'b1) begin
              a_ready <= 1'b0;
              state   <= S_POOL;
            end
          end else begin
            // stall: A and read address hold, PEs see an idle beat
            pe_state <= PE_INVALID;
          end
        end
        S_POOL: begin
          if (pool_cnt == POOL_W'(POOL_CYC)) begin
            pe_state <= PE_POOL_FIN;
            done     <= 1'b1;
            state    <= S_FIN;
          end else begin
            pe_state <= PE_POOL;
            pool_cnt <= pool_cnt + 1'b1;
          end
        end
        S_FIN: begin
          pe_state <= PE_INVALID;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CNN_SEQ_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Stall counter: cleared per layer, saturating, frozen outside CONV
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (state == S_IDLE && start)
      stall_cnt <= '0;
    else if (state == S_CONV && a_ready && !a_valid)
      stall_cnt <= sat_inc(stall_cnt);
  end
`endif

endmodule
